// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int ARB_CNT_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_lat_counter.sv
// Access-latency counter: runs 0..MEM_LAT-1 while enabled and flags the last cycle.
module arb_lat_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam logic [ARB_CNT_W-1:0] CNT_LAST = ARB_CNT_W'(MEM_LAT - 1);

  logic [ARB_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (enable)    cnt <= cnt + 1'b1;
  end

  assign last = (cnt == CNT_LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data ports, data first,
// with a fixed access latency and one-cycle completion pulses.
//
// state      | meaning
// ARB_IDLE   | no access in flight; grant decision made this cycle
// ARB_BUSY_I | fetch access in progress on the memory port
// ARB_BUSY_D | data load/store in progress on the memory port
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
    $fatal(1, "mem_port_arbiter: MEM_LAT must be within 1..15");
  end

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              if_valid_q, d_valid_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              busy, last;
  logic              d_req_m, if_req_m;
  logic              grant_d, grant_i;

  assign busy = (state_q != ARB_IDLE);

  // A port is masked in its own completion cycle so a held request is not re-served.
  assign d_req_m  = d_req  & ~d_valid_q;
  assign if_req_m = if_req & ~if_valid_q;

  arb_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (~busy | last),
    .enable (busy),
    .last   (last)
  );

  always_comb begin
    state_d = state_q;
    grant_d = 1'b0;
    grant_i = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (d_req_m) begin
          state_d = ARB_BUSY_D;
          grant_d = 1'b1;
        end else if (if_req_m) begin
          state_d = ARB_BUSY_I;
          grant_i = 1'b1;
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (last) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if (grant_d) begin
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
        we_q    <= d_we;
      end else if (grant_i) begin
        addr_q <= if_addr;
        we_q   <= 1'b0;
      end
      if (state_q == ARB_BUSY_I && last) begin
        if_valid_q <= 1'b1;
        if_rdata_q <= mem_rdata;
      end
      // Stores complete without touching the load data register.
      if (state_q == ARB_BUSY_D && last) begin
        d_valid_q <= 1'b1;
        if (!we_q) d_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_en    = busy;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q & (state_q == ARB_BUSY_D) & last & ~reset;

  assign if_valid = if_valid_q;
  assign d_valid  = d_valid_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign stall    = (if_req & ~if_valid_q) | (d_req & ~d_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against
// a transaction-level schedule model, at MEM_LAT=2 and MEM_LAT=1.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        lat_sel;

  logic [31:0] if_rdata_2, d_rdata_2, mem_addr_2, mem_wdata_2, mem_rdata_2;
  logic        if_valid_2, d_valid_2, stall_2, mem_en_2, mem_we_2;
  logic [31:0] if_rdata_1, d_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
  logic        if_valid_1, d_valid_1, stall_1, mem_en_1, mem_we_1;

  logic [31:0] o_if_rdata, o_d_rdata, o_mem_addr, o_mem_wdata;
  logic        o_if_valid, o_d_valid, o_stall, o_mem_en, o_mem_we;

  logic [31:0] tbmem [0:255];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign mem_rdata_2 = tbmem[mem_addr_2[9:2]];
  assign mem_rdata_1 = tbmem[mem_addr_1[9:2]];

  mem_port_arbiter #(.MEM_LAT(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_2), .if_valid(if_valid_2),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata_2), .d_valid(d_valid_2), .stall(stall_2),
    .mem_en(mem_en_2), .mem_we(mem_we_2), .mem_addr(mem_addr_2),
    .mem_wdata(mem_wdata_2), .mem_rdata(mem_rdata_2)
  );

  mem_port_arbiter #(.MEM_LAT(1), .ADDR_W(32), .DATA_W(32)) dut_lat1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_1), .if_valid(if_valid_1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata_1), .d_valid(d_valid_1), .stall(stall_1),
    .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1),
    .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1)
  );

  assign o_if_rdata  = lat_sel ? if_rdata_1  : if_rdata_2;
  assign o_d_rdata   = lat_sel ? d_rdata_1   : d_rdata_2;
  assign o_mem_addr  = lat_sel ? mem_addr_1  : mem_addr_2;
  assign o_mem_wdata = lat_sel ? mem_wdata_1 : mem_wdata_2;
  assign o_if_valid  = lat_sel ? if_valid_1  : if_valid_2;
  assign o_d_valid   = lat_sel ? d_valid_1   : d_valid_2;
  assign o_stall     = lat_sel ? stall_1     : stall_2;
  assign o_mem_en    = lat_sel ? mem_en_1    : mem_en_2;
  assign o_mem_we    = lat_sel ? mem_we_1    : mem_we_2;

  task automatic test_reset();
    lat_sel = 1'b0;
    @(negedge clk);
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (o_if_valid !== 1'b0) begin failures++; $display("FAIL reset_if_valid got=%b exp=0", o_if_valid); end
    checks++; if (o_d_valid !== 1'b0) begin failures++; $display("FAIL reset_d_valid got=%b exp=0", o_d_valid); end
    checks++; if (o_if_rdata !== 32'h0) begin failures++; $display("FAIL reset_if_rdata got=%h exp=0", o_if_rdata); end
    checks++; if (o_d_rdata !== 32'h0) begin failures++; $display("FAIL reset_d_rdata got=%h exp=0", o_d_rdata); end
    checks++; if (o_mem_en !== 1'b0 || o_mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_ctl got=%b%b exp=00", o_mem_en, o_mem_we); end
    checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", o_stall); end
    checks++; if (o_mem_addr !== 32'h0 || o_mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_latched got=%h/%h exp=0/0", o_mem_addr, o_mem_wdata); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (o_mem_en !== 1'b0 || o_stall !== 1'b0) begin failures++; $display("FAIL reset_idle got=%b%b exp=00", o_mem_en, o_stall); end
  endtask

  task automatic test_lone_fetch();
    lat_sel = 1'b0;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h40;
      #1;
      checks++; if (o_mem_en !== 1'((c == 1) || (c == 2))) begin failures++; $display("FAIL fetch_en c=%0d got=%b", c, o_mem_en); end
      if (c == 1 || c == 2) begin
        checks++; if (o_mem_addr !== 32'h40) begin failures++; $display("FAIL fetch_addr c=%0d got=%h exp=00000040", c, o_mem_addr); end
      end
      checks++; if (o_if_valid !== 1'(c == 3)) begin failures++; $display("FAIL fetch_valid c=%0d got=%b", c, o_if_valid); end
      if (c == 3) begin
        checks++; if (o_if_rdata !== 32'h20100005) begin failures++; $display("FAIL fetch_rdata got=%h exp=20100005", o_if_rdata); end
      end
      checks++; if (o_stall !== 1'(c < 3)) begin failures++; $display("FAIL fetch_stall c=%0d got=%b", c, o_stall); end
    end
    @(negedge clk);
    if_req = 1'b0;
  endtask

  task automatic test_contention();
    lat_sel = 1'b0;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      d_req = (c <= 3); d_we = 1'b0; d_addr = 32'h100;
      if_req = 1'b1; if_addr = 32'h44;
      #1;
      checks++; if (o_mem_en !== 1'(c == 1 || c == 2 || c == 4 || c == 5)) begin failures++; $display("FAIL cont_en c=%0d got=%b", c, o_mem_en); end
      if (c == 1 || c == 2) begin
        checks++; if (o_mem_addr !== 32'h100) begin failures++; $display("FAIL cont_daddr c=%0d got=%h exp=00000100", c, o_mem_addr); end
      end
      if (c == 4 || c == 5) begin
        checks++; if (o_mem_addr !== 32'h44) begin failures++; $display("FAIL cont_iaddr c=%0d got=%h exp=00000044", c, o_mem_addr); end
      end
      checks++; if (o_d_valid !== 1'(c == 3)) begin failures++; $display("FAIL cont_dvalid c=%0d got=%b", c, o_d_valid); end
      checks++; if (o_if_valid !== 1'(c == 6)) begin failures++; $display("FAIL cont_ivalid c=%0d got=%b", c, o_if_valid); end
      if (c == 3) begin
        checks++; if (o_d_rdata !== 32'h00C0FFEE) begin failures++; $display("FAIL cont_drdata got=%h exp=00c0ffee", o_d_rdata); end
      end
      if (c == 6) begin
        checks++; if (o_if_rdata !== 32'h8C020000) begin failures++; $display("FAIL cont_irdata got=%h exp=8c020000", o_if_rdata); end
      end
      checks++; if (o_stall !== 1'(c <= 5)) begin failures++; $display("FAIL cont_stall c=%0d got=%b", c, o_stall); end
    end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_store();
    lat_sel = 1'b0;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h84; d_wdata = 32'hDEADBEEF;
      #1;
      checks++; if (o_mem_we !== 1'(c == 2)) begin failures++; $display("FAIL store_we c=%0d got=%b", c, o_mem_we); end
      if (c == 2) begin
        checks++; if (o_mem_addr !== 32'h84 || o_mem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL store_bus got=%h/%h exp=00000084/deadbeef", o_mem_addr, o_mem_wdata); end
      end
      checks++; if (o_d_valid !== 1'(c == 3)) begin failures++; $display("FAIL store_valid c=%0d got=%b", c, o_d_valid); end
      if (c == 3) begin
        checks++; if (o_d_rdata !== 32'h00C0FFEE) begin failures++; $display("FAIL store_rdata_kept got=%h exp=00c0ffee", o_d_rdata); end
      end
    end
    @(negedge clk);
    d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic test_reset_mid_store();
    lat_sel = 1'b0;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h84; d_wdata = 32'hDEADBEEF;
      reset = (c == 2);
      #1;
      checks++; if (o_mem_we !== 1'(c == 5)) begin failures++; $display("FAIL rst_store_we c=%0d got=%b", c, o_mem_we); end
      if (c == 3) begin
        checks++; if (o_mem_en !== 1'b0 || o_d_valid !== 1'b0 || o_stall !== 1'b1) begin failures++; $display("FAIL rst_store_idle en/valid/stall got=%b%b%b exp=001", o_mem_en, o_d_valid, o_stall); end
      end
      if (c == 4) begin
        checks++; if (o_mem_en !== 1'b1) begin failures++; $display("FAIL rst_store_regrant got=%b exp=1", o_mem_en); end
      end
      checks++; if (o_d_valid !== 1'(c == 6)) begin failures++; $display("FAIL rst_store_valid c=%0d got=%b", c, o_d_valid); end
    end
    @(negedge clk);
    d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic test_back_to_back();
    lat_sel = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      logic [31:0] a;
      if (c > 0) @(negedge clk);
      a = (c <= 2) ? 32'h0 : ((c <= 5) ? 32'h4 : 32'h8);
      if_req = 1'b1; if_addr = a;
      #1;
      checks++; if (o_mem_en !== 1'(c == 1 || c == 4 || c == 7)) begin failures++; $display("FAIL b2b_en c=%0d got=%b", c, o_mem_en); end
      if (c == 1 || c == 4 || c == 7) begin
        checks++; if (o_mem_addr !== a) begin failures++; $display("FAIL b2b_addr c=%0d got=%h exp=%h", c, o_mem_addr, a); end
      end
      checks++; if (o_if_valid !== 1'(c == 2 || c == 5 || c == 8)) begin failures++; $display("FAIL b2b_valid c=%0d got=%b", c, o_if_valid); end
      if (c == 2 || c == 5 || c == 8) begin
        checks++; if (o_if_rdata !== tbmem[a[9:2]]) begin failures++; $display("FAIL b2b_rdata c=%0d got=%h exp=%h", c, o_if_rdata, tbmem[a[9:2]]); end
      end
    end
    @(negedge clk);
    if_req = 1'b0;
  endtask

  // Transaction-level model: a grant in an idle cycle g occupies the memory for
  // cycles g+1..g+L and pulses valid at g+L+1, which is again an idle cycle.
  task automatic test_random(input logic lsel, input int ncyc);
    int L, owner, g, vi, vd;
    logic [31:0] ma, mwd, ei, ed, ia, da, dwd;
    logic mwe, dwe_r, ipend, dpend;
    logic exp_we, exp_stall;
    lat_sel = lsel;
    L = lsel ? 1 : 2;
    @(negedge clk);
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    owner = 0; g = 0; vi = -10; vd = -10; ei = '0; ed = '0;
    ma = '0; mwd = '0; mwe = 1'b0; ipend = 1'b0; dpend = 1'b0;
    ia = '0; da = '0; dwd = '0; dwe_r = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) @(negedge clk);
      if (ipend && vi == c - 1) ipend = 1'b0;
      if (!ipend && $urandom_range(2) == 0) begin
        ipend = 1'b1; ia = 32'($urandom_range(255)) << 2;
      end
      if (dpend && vd == c - 1) dpend = 1'b0;
      if (!dpend && $urandom_range(3) == 0) begin
        dpend = 1'b1; da = 32'($urandom_range(255)) << 2;
        dwe_r = 1'($urandom_range(1)); dwd = $urandom;
      end
      if_req = ipend;
      if_addr = (owner == 1) ? $urandom : ia;
      d_req = dpend; d_we = dwe_r;
      d_addr = (owner == 2) ? $urandom : da;
      d_wdata = (owner == 2) ? $urandom : dwd;
      #1;
      exp_we = (owner == 2) && mwe && (c == g + L);
      exp_stall = (if_req && vi != c) || (d_req && vd != c);
      checks++; if (o_mem_en !== 1'(owner != 0)) begin failures++; $display("FAIL rnd_en L=%0d c=%0d got=%b", L, c, o_mem_en); end
      checks++; if (o_mem_we !== exp_we) begin failures++; $display("FAIL rnd_we L=%0d c=%0d got=%b exp=%b", L, c, o_mem_we, exp_we); end
      checks++; if (o_stall !== exp_stall) begin failures++; $display("FAIL rnd_stall L=%0d c=%0d got=%b exp=%b", L, c, o_stall, exp_stall); end
      checks++; if (o_if_valid !== 1'(vi == c)) begin failures++; $display("FAIL rnd_ivalid L=%0d c=%0d got=%b", L, c, o_if_valid); end
      checks++; if (o_d_valid !== 1'(vd == c)) begin failures++; $display("FAIL rnd_dvalid L=%0d c=%0d got=%b", L, c, o_d_valid); end
      if (owner != 0) begin
        checks++; if (o_mem_addr !== ma) begin failures++; $display("FAIL rnd_addr L=%0d c=%0d got=%h exp=%h", L, c, o_mem_addr, ma); end
      end
      if (exp_we) begin
        checks++; if (o_mem_wdata !== mwd) begin failures++; $display("FAIL rnd_wdata L=%0d c=%0d got=%h exp=%h", L, c, o_mem_wdata, mwd); end
      end
      if (vi == c) begin
        checks++; if (o_if_rdata !== ei) begin failures++; $display("FAIL rnd_irdata L=%0d c=%0d got=%h exp=%h", L, c, o_if_rdata, ei); end
      end
      if (vd == c) begin
        checks++; if (o_d_rdata !== ed) begin failures++; $display("FAIL rnd_drdata L=%0d c=%0d got=%h exp=%h", L, c, o_d_rdata, ed); end
      end
      if (owner != 0 && c == g + L) begin
        if (owner == 1) begin
          vi = c + 1; ei = tbmem[ma[9:2]];
        end else begin
          vd = c + 1;
          if (mwe) tbmem[ma[9:2]] = mwd;
          else     ed = tbmem[ma[9:2]];
        end
        owner = 0;
      end else if (owner == 0) begin
        if (d_req && vd != c) begin
          owner = 2; g = c; ma = d_addr; mwe = d_we; mwd = d_wdata;
        end else if (if_req && vi != c) begin
          owner = 1; g = c; ma = if_addr; mwe = 1'b0;
        end
      end
    end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; lat_sel = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 256; i++) tbmem[i] = $urandom;
    tbmem[16] = 32'h20100005;
    tbmem[17] = 32'h8C020000;
    tbmem[64] = 32'h00C0FFEE;
    test_reset();
    test_lone_fetch();
    test_contention();
    test_store();
    test_reset_mid_store();
    test_back_to_back();
    test_random(1'b0, 400);
    test_random(1'b1, 400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
